// File: rtl/xor_descrambler.sv
// rtl/xor_descrambler.sv - streaming 6-bit LFSR XOR descrambler with registered output stage
module xor_descrambler #(
    parameter logic [5:0] SEED = 6'b000001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seed_load,
    input  logic [5:0] seed,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic [7:0] word_count
);

    typedef enum logic {
        LOCKED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] key;
    logic [5:0] key_next;
    logic       accept;

    // x^6 + x^5 + 1, Fibonacci form; never reaches the all-zero state
    assign key_next = {key[4:0], key[5] ^ key[4]};
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        if (seed_load) begin
            state_nxt = RUN;
        end
        // a seed load always wins over a word offered in the same cycle
        if (state == RUN) begin
            in_ready = !seed_load && (!out_valid || out_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key        <= SEED;
            out_valid  <= 1'b0;
            out_data   <= 6'd0;
            word_count <= 8'd0;
        end else if (seed_load) begin
            key        <= (seed == 6'd0) ? SEED : seed;
            out_valid  <= 1'b0;
            word_count <= 8'd0;
        end else if (accept) begin
            out_data   <= in_data ^ key;
            out_valid  <= 1'b1;
            key        <= key_next;
            word_count <= word_count + 8'd1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_descrambler.sv
// tb/tb_xor_descrambler.sv - scoreboard bench for xor_descrambler against a keystream model
module tb_xor_descrambler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_load;
    logic [5:0] seed;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic [7:0] word_count;

    xor_descrambler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [5:0] exp_q[$];
    logic       m_running = 1'b0;
    logic       m_ov      = 1'b0;
    int         m_key     = 1;
    int         m_cnt     = 0;
    bit         chk_en    = 1'b0;

    logic [5:0] t1_exp[7];
    logic [5:0] hold;
    logic [5:0] s_new;
    logic [5:0] d0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_step(input int k);
        return ((k * 2) % 64) + (((k / 32) + (k / 16)) % 2);
    endfunction

    // Evaluate the cycle's inputs against the model, then advance to just after the edge.
    task automatic step();
        bit exp_ready;
        @(negedge clk);
        #1;
        exp_ready = m_running && !seed_load && (!m_ov || out_ready);
        if (chk_en) begin
            check("in_ready", int'(in_ready), int'(exp_ready));
            check("out_valid", int'(out_valid), int'(m_ov));
            check("word_count", int'(word_count), m_cnt);
        end
        if (!rst_n) begin
            m_running = 1'b0;
            m_ov      = 1'b0;
            m_key     = 1;
            m_cnt     = 0;
            exp_q.delete();
        end else if (seed_load) begin
            m_running = 1'b1;
            m_ov      = 1'b0;
            m_key     = (seed == 6'd0) ? 1 : int'(seed);
            m_cnt     = 0;
            exp_q.delete();
        end else if (in_valid && exp_ready) begin
            exp_q.push_back(in_data ^ 6'(m_key));
            m_key = lfsr_step(m_key);
            m_cnt = (m_cnt + 1) % 256;
            m_ov  = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (chk_en && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_output: got %0h expected none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_out", int'(out_data), int'(e));
                end
            end
        end
    end

    initial begin
        t1_exp = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
        rst_n = 1'b0; seed_load = 1'b0; seed = 6'd0;
        in_valid = 1'b0; in_data = 6'd0; out_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_out_data", int'(out_data), 0);
        rst_n = 1'b1;

        // LOCKED: nothing is accepted without a seed
        in_valid = 1'b1;
        repeat (10) begin
            in_data = 6'($urandom);
            step();
        end

        // seed 01, seven zero words expose the keystream directly
        in_valid = 1'b0; seed_load = 1'b1; seed = 6'h01;
        step();
        seed_load = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 6'h00;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t1_word", int'(out_data), int'(t1_exp[i]));
        end
        in_valid = 1'b0;
        step();
        check("t1_count", int'(word_count), 7);

        // scramble then descramble round trip
        seed_load = 1'b1; seed = 6'h01;
        step();
        seed_load = 1'b0; in_valid = 1'b1; in_data = 6'h3F;
        step();
        check("rt_scramble", int'(out_data), 6'h3E);
        in_valid = 1'b0; seed_load = 1'b1;
        step();
        seed_load = 1'b0; in_valid = 1'b1; in_data = 6'h3E;
        step();
        check("rt_recover", int'(out_data), 6'h3F);
        in_valid = 1'b0;

        // zero seed substitutes SEED; full period returns to it
        seed_load = 1'b1; seed = 6'h00;
        step();
        seed_load = 1'b0; in_valid = 1'b1;
        repeat (63) begin
            in_data = 6'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        check("period_count", int'(word_count), 63);
        in_valid = 1'b1; in_data = 6'h00;
        step();
        check("period_key", int'(out_data), 6'h01);
        in_valid = 1'b0;
        step();

        // backpressure holds data and key
        seed_load = 1'b1; seed = 6'h01;
        step();
        seed_load = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 6'($urandom);
        step();
        hold = out_data;
        d0 = 6'($urandom);
        in_data = d0;
        repeat (5) begin
            step();
            check("bp_hold_data", int'(out_data), int'(hold));
            check("bp_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_key", int'(out_data), int'(d0 ^ 6'h02));
        in_valid = 1'b0;
        step();

        // seed_load wins over a simultaneous word
        out_ready = 1'b0; in_valid = 1'b1; in_data = 6'($urandom);
        step();
        s_new = 6'($urandom_range(1, 63));
        d0 = 6'($urandom);
        seed_load = 1'b1; seed = s_new; in_data = d0;
        step();
        check("sl_valid", int'(out_valid), 0);
        check("sl_count", int'(word_count), 0);
        seed_load = 1'b0; out_ready = 1'b1;
        step();
        check("sl_first_word", int'(out_data), int'(d0 ^ s_new));
        in_valid = 1'b0;
        step();

        // word_count wraps modulo 256
        seed_load = 1'b1; seed = 6'($urandom);
        step();
        seed_load = 1'b0; in_valid = 1'b1;
        repeat (260) begin
            in_data = 6'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        check("wrap_count", int'(word_count), 4);

        // randomized traffic with occasional reseeds
        for (int i = 0; i < 800; i++) begin
            seed_load = ($urandom_range(0, 49) == 0);
            seed      = 6'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 6'($urandom);
            step();
        end
        seed_load = 1'b0;

        // reset mid-stream drops the pending word and relocks
        out_ready = 1'b0; in_valid = 1'b1; in_data = 6'($urandom);
        step();
        check("mid_valid_before", int'(out_valid), 1);
        rst_n = 1'b0;
        step();
        check("mid_valid_after", int'(out_valid), 0);
        rst_n = 1'b1;
        repeat (3) step();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
